// File: rtl/chorus_delay_ctrl.sv
// rtl/chorus_delay_ctrl.sv - chorus delay buffer sequencer with triangle-LFO modulated read tap
// One transaction per accepted strobe: write dry sample, read delayed tap, mix, emit.

module chorus_delay_ctrl #(
  parameter int MEM_WIDTH  = 16,
  parameter int MEM_DEPTH  = 16,
  parameter int RD_LAT     = 1,
  parameter int BASE_DELAY = 960,
  parameter int MOD_DEPTH  = 480,
  parameter int LFO_DIV    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MEM_WIDTH-1:0] sample_in,
  input  logic                 sample_valid,
  input  logic                 bypass,
  output logic [MEM_WIDTH-1:0] sample_out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 wea,
  output logic [MEM_DEPTH-1:0] addra,
  output logic [MEM_WIDTH-1:0] dina,
  output logic [MEM_DEPTH-1:0] addrb,
  input  logic [MEM_WIDTH-1:0] doutb
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int DIV_W = (LFO_DIV > 1) ? $clog2(LFO_DIV + 1) : 1;
  localparam logic [MEM_DEPTH-1:0] BASE_L   = MEM_DEPTH'(BASE_DELAY);
  localparam logic [MEM_DEPTH-1:0] MOD_L    = MEM_DEPTH'(MOD_DEPTH);
  localparam logic [MEM_DEPTH-1:0] ONE_A    = MEM_DEPTH'(1);
  localparam logic [MEM_DEPTH-1:0] FILL_MAX = {MEM_DEPTH{1'b1}};
  localparam logic [LAT_W-1:0]     LAT_INIT = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0]     LAT_ONE  = LAT_W'(1);
  localparam logic [DIV_W-1:0]     DIV_L    = DIV_W'(LFO_DIV);
  localparam logic [DIV_W-1:0]     DIV_ONE  = DIV_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_MIX} state_e;

  state_e               state_q, state_d;
  logic [MEM_WIDTH-1:0] dry_q;
  logic                 byp_q;
  logic [MEM_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [MEM_DEPTH-1:0] fill_q, fill_d;
  logic [MEM_DEPTH-1:0] lfo_q, lfo_d;
  logic                 lfo_up_q, lfo_up_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
  logic [MEM_WIDTH-1:0] sample_out_q;
  logic                 out_valid_q, overrun_q, wea_q;
  logic [MEM_DEPTH-1:0] addra_q, addrb_q;
  logic [MEM_WIDTH-1:0] dina_q;

  logic                 accept, mix_en;
  logic [MEM_DEPTH-1:0] delay;
  logic [MEM_WIDTH-1:0] wet, mix_out;
  logic [MEM_WIDTH:0]   sum;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sample_valid) state_d = S_ISSUE;
      S_ISSUE: state_d = (RD_LAT > 1) ? S_WAIT : S_MIX;
      S_WAIT:  if (lat_cnt_q == LAT_ONE) state_d = S_MIX;
      S_MIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    accept = 1'b0;
    mix_en = 1'b0;
    case (state_q)
      S_IDLE:  accept = sample_valid;
      S_ISSUE: busy = 1'b1;
      S_WAIT:  busy = 1'b1;
      S_MIX: begin
        busy   = 1'b1;
        mix_en = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // lfo only moves in MIX, so the same delay serves the ISSUE address and the MIX primed test
  assign delay   = BASE_L + lfo_q;
  assign wet     = (fill_q >= delay) ? doutb : '0;
  assign sum     = {dry_q[MEM_WIDTH-1], dry_q} + {wet[MEM_WIDTH-1], wet};
  assign mix_out = byp_q ? dry_q : MEM_WIDTH'(sum >> 1);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    lfo_d     = lfo_q;
    lfo_up_d  = lfo_up_q;
    div_cnt_d = div_cnt_q;
    lat_cnt_d = lat_cnt_q;
    if (state_q == S_ISSUE)     lat_cnt_d = LAT_INIT;
    else if (state_q == S_WAIT) lat_cnt_d = lat_cnt_q - LAT_ONE;
    if (mix_en) begin
      wr_ptr_d = wr_ptr_q + ONE_A;
      if (fill_q != FILL_MAX) fill_d = fill_q + ONE_A;
      if (div_cnt_q + DIV_ONE == DIV_L) begin
        div_cnt_d = '0;
        if (MOD_DEPTH != 0) begin
          if (lfo_up_q) begin
            lfo_d = lfo_q + ONE_A;
            if (lfo_d == MOD_L) lfo_up_d = 1'b0;
          end else begin
            lfo_d = lfo_q - ONE_A;
            if (lfo_d == '0) lfo_up_d = 1'b1;
          end
        end
      end else begin
        div_cnt_d = div_cnt_q + DIV_ONE;
      end
    end
  end

  // Memory-side outputs load on acceptance so they are already registered during ISSUE
  always_ff @(posedge clk) begin
    if (reset) begin
      dry_q        <= '0;
      byp_q        <= 1'b0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      lfo_q        <= '0;
      lfo_up_q     <= 1'b1;
      div_cnt_q    <= '0;
      lat_cnt_q    <= '0;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      wea_q        <= 1'b0;
      addra_q      <= '0;
      addrb_q      <= '0;
      dina_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      lfo_q       <= lfo_d;
      lfo_up_q    <= lfo_up_d;
      div_cnt_q   <= div_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      wea_q       <= accept;
      out_valid_q <= mix_en;
      if (sample_valid && busy) overrun_q <= 1'b1;
      if (accept) begin
        dry_q   <= sample_in;
        byp_q   <= bypass;
        addra_q <= wr_ptr_q;
        dina_q  <= sample_in;
        addrb_q <= wr_ptr_q - delay;
      end
      if (mix_en) sample_out_q <= mix_out;
    end
  end

  assign sample_out = sample_out_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;
  assign wea        = wea_q;
  assign addra      = addra_q;
  assign addrb      = addrb_q;
  assign dina       = dina_q;

endmodule

// File: tb/tb_chorus_delay_ctrl.sv
// tb/tb_chorus_delay_ctrl.sv - bench for chorus_delay_ctrl with two parameter sets
// Instance a: RD_LAT=1, BASE=2, MOD=0. Instance b: RD_LAT=2, BASE=4, MOD=2, LFO_DIV=1.

module tb_chorus_delay_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, sv_a = 1'b0, byp_a = 1'b0;
  logic [15:0] sin_a = '0;
  logic [15:0] so_a, dina_a, doutb_a;
  logic        ov_a, busy_a, ovr_a, wea_a;
  logic [3:0]  addra_a, addrb_a;

  logic        rst_b = 1'b1, sv_b = 1'b0, byp_b = 1'b0;
  logic [15:0] sin_b = '0;
  logic [15:0] so_b, dina_b, doutb_b;
  logic        ov_b, busy_b, ovr_b, wea_b;
  logic [3:0]  addra_b, addrb_b;

  chorus_delay_ctrl #(.MEM_WIDTH(16), .MEM_DEPTH(4), .RD_LAT(1), .BASE_DELAY(2),
                      .MOD_DEPTH(0), .LFO_DIV(3)) u_dut_a (
    .clk(clk), .reset(rst_a), .sample_in(sin_a), .sample_valid(sv_a), .bypass(byp_a),
    .sample_out(so_a), .out_valid(ov_a), .busy(busy_a), .overrun(ovr_a),
    .wea(wea_a), .addra(addra_a), .dina(dina_a), .addrb(addrb_a), .doutb(doutb_a));

  chorus_delay_ctrl #(.MEM_WIDTH(16), .MEM_DEPTH(4), .RD_LAT(2), .BASE_DELAY(4),
                      .MOD_DEPTH(2), .LFO_DIV(1)) u_dut_b (
    .clk(clk), .reset(rst_b), .sample_in(sin_b), .sample_valid(sv_b), .bypass(byp_b),
    .sample_out(so_b), .out_valid(ov_b), .busy(busy_b), .overrun(ovr_b),
    .wea(wea_b), .addra(addra_b), .dina(dina_b), .addrb(addrb_b), .doutb(doutb_b));

  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];
  logic [15:0] pipe_b;

  always @(posedge clk) begin
    if (wea_a) mem_a[addra_a] <= dina_a;
    doutb_a <= mem_a[addrb_a];
  end

  always @(posedge clk) begin
    if (wea_b) mem_b[addra_b] <= dina_b;
    pipe_b  <= mem_b[addrb_b];
    doutb_b <= pipe_b;
  end

  int rl   [2] = '{1, 2};
  int base [2] = '{2, 4};
  int modd [2] = '{0, 2};
  int divv [2] = '{3, 1};

  int ecnt = 0;
  int n_s [2] = '{0, 0};
  int ready_at [2] = '{0, 0};
  int wea_edge [2] = '{-100, -100};
  int out_edge [2] = '{-100, -100};
  int ovr_m [2] = '{0, 0};
  int exp_addra [2] = '{0, 0};
  int exp_addrb [2] = '{0, 0};
  int exp_dina [2] = '{0, 0};
  int exp_out [2] = '{0, 0};
  int pend_out [2] = '{0, 0};
  int hist [2][1024];

  int total = 0;
  int bad = 0;

  int outq_a[$], oute_a[$], waq_a[$], wbq_a[$], se_a[$];
  int oute_b[$], waq_b[$], offq_b[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Triangle position after floor(n/div) steps of a 0..m..0 sweep
  function automatic int lfo_of(input int n, input int m, input int div);
    int p;
    if (m == 0) return 0;
    p = (n / div) % (2 * m);
    return (p <= m) ? p : 2 * m - p;
  endfunction

  task automatic model_edge(input int i, input logic r, input logic v, input int d, input logic b);
    int dl, wet;
    if (r) begin
      n_s[i] = 0; ready_at[i] = 0; wea_edge[i] = -100; out_edge[i] = -100; ovr_m[i] = 0;
      exp_addra[i] = 0; exp_addrb[i] = 0; exp_dina[i] = 0; exp_out[i] = 0;
    end else begin
      if (ecnt == out_edge[i]) exp_out[i] = pend_out[i];
      if (v) begin
        if (ecnt < ready_at[i]) begin
          ovr_m[i] = 1;
        end else begin
          dl = base[i] + lfo_of(n_s[i], modd[i], divv[i]);
          exp_addra[i] = n_s[i] % 16;
          exp_addrb[i] = ((n_s[i] - dl) % 16 + 16) % 16;
          exp_dina[i] = d & 32'hFFFF;
          hist[i][n_s[i]] = d;
          wet = (n_s[i] >= dl) ? hist[i][n_s[i] - dl] : 0;
          pend_out[i] = b ? (d & 32'hFFFF) : (((d + wet) >>> 1) & 32'hFFFF);
          wea_edge[i] = ecnt;
          out_edge[i] = ecnt + rl[i] + 1;
          ready_at[i] = ecnt + rl[i] + 2;
          n_s[i]++;
        end
      end
    end
  endtask

  task automatic compare(input int i, input logic [15:0] so, input logic ov, input logic bz,
                         input logic ovr, input logic we, input logic [3:0] aa,
                         input logic [3:0] ab, input logic [15:0] di);
    string p;
    p = (i == 0) ? "a" : "b";
    check({p, "_wea"}, int'(we), (ecnt == wea_edge[i]) ? 1 : 0);
    check({p, "_out_valid"}, int'(ov), (ecnt == out_edge[i]) ? 1 : 0);
    check({p, "_busy"}, int'(bz), (ecnt >= wea_edge[i] && ecnt <= wea_edge[i] + rl[i]) ? 1 : 0);
    check({p, "_overrun"}, int'(ovr), ovr_m[i]);
    check({p, "_addra"}, int'(aa), exp_addra[i]);
    check({p, "_addrb"}, int'(ab), exp_addrb[i]);
    check({p, "_dina"}, int'(di), exp_dina[i]);
    check({p, "_sample_out"}, int'(so), exp_out[i]);
  endtask

  task automatic tick();
    logic [3:0] off;
    @(posedge clk);
    ecnt++;
    model_edge(0, rst_a, sv_a, int'($signed(sin_a)), byp_a);
    model_edge(1, rst_b, sv_b, int'($signed(sin_b)), byp_b);
    @(negedge clk);
    compare(0, so_a, ov_a, busy_a, ovr_a, wea_a, addra_a, addrb_a, dina_a);
    compare(1, so_b, ov_b, busy_b, ovr_b, wea_b, addra_b, addrb_b, dina_b);
    if (ov_a) begin outq_a.push_back(int'(so_a)); oute_a.push_back(ecnt); end
    if (wea_a) begin waq_a.push_back(int'(addra_a)); wbq_a.push_back(int'(addrb_a)); end
    if (ov_b) oute_b.push_back(ecnt);
    if (wea_b) begin
      off = addra_b - addrb_b;
      waq_b.push_back(int'(addra_b));
      offq_b.push_back(int'(off));
    end
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  task automatic strobe(input int i, input logic [15:0] d, input logic b);
    if (i == 0) begin sv_a = 1'b1; sin_a = d; byp_a = b; end
    else        begin sv_b = 1'b1; sin_b = d; byp_b = b; end
    tick();
    sv_a = 1'b0; sv_b = 1'b0;
  endtask

  int prime_exp [4] = '{50, 100, 200, 300};
  int lfo_exp [7] = '{4, 5, 6, 5, 4, 5, 6};
  int ke;

  initial begin
    idle(3);
    rst_a = 1'b0; rst_b = 1'b0;
    idle(1);
    check("a_reset_sample_out", int'(so_a), 0);
    check("b_reset_busy", int'(busy_b), 0);

    // Priming: two samples of silence before the 2-sample tap fills
    outq_a.delete(); oute_a.delete(); waq_a.delete(); wbq_a.delete(); se_a.delete();
    for (int k = 0; k < 4; k++) begin
      strobe(0, 16'(100 * (k + 1)), 1'b0);
      se_a.push_back(ecnt);
      idle(3);
    end
    check("a_prime_count", outq_a.size(), 4);
    if (outq_a.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("a_prime_value", outq_a[k], prime_exp[k]);
        check("a_prime_latency", oute_a[k] - se_a[k], 2);
      end
    end

    // Wrap at minimum strobe spacing
    for (int k = 0; k < 16; k++) begin
      strobe(0, 16'($urandom), 1'b0);
      idle(2);
    end
    idle(3);
    check("a_wrap_count", waq_a.size(), 20);
    if (waq_a.size() == 20) begin
      for (int k = 0; k < 20; k++) begin
        check("a_wrap_addra", waq_a[k], k % 16);
        if (waq_a[k] == 1) check("a_wrap_addrb", wbq_a[k], 15);
      end
    end

    // Reset held for three cycles starting in ISSUE
    strobe(0, 16'h5555, 1'b0);
    check("a_issue_wea", int'(wea_a), 1);
    rst_a = 1'b1;
    tick();
    check("a_rst_wea", int'(wea_a), 0);
    check("a_rst_out_valid", int'(ov_a), 0);
    check("a_rst_sample_out", int'(so_a), 0);
    check("a_rst_overrun", int'(ovr_a), 0);
    check("a_rst_busy", int'(busy_a), 0);
    idle(2);
    rst_a = 1'b0;
    idle(1);
    waq_a.delete(); outq_a.delete();

    // Mix arithmetic: saturating extremes, floor of -1/2, bypass
    strobe(0, 16'h7FFF, 1'b0); idle(2);
    check("a_post_rst_addra", (waq_a.size() > 0) ? waq_a[0] : -1, 0);
    strobe(0, 16'h7FFF, 1'b0); idle(2);
    strobe(0, 16'h7FFF, 1'b0); idle(2);
    strobe(0, 16'h8000, 1'b0); idle(2);
    strobe(0, 16'h8000, 1'b0); idle(2);
    strobe(0, 16'h8000, 1'b0); idle(2);
    strobe(0, 16'h0000, 1'b0); idle(2);
    strobe(0, 16'h0000, 1'b0); idle(2);
    strobe(0, 16'hFFFF, 1'b0); idle(2);
    strobe(0, 16'h1234, 1'b1); idle(3);
    check("a_mix_count", outq_a.size(), 10);
    if (outq_a.size() == 10) begin
      check("a_mix_max", outq_a[2], 32'h7FFF);
      check("a_mix_min", outq_a[5], 32'h8000);
      check("a_mix_floor", outq_a[8], 32'hFFFF);
      check("a_mix_bypass", outq_a[9], 32'h1234);
    end

    // LFO sweep on b: tap offset follows the triangle
    offq_b.delete(); waq_b.delete();
    for (int k = 0; k < 7; k++) begin
      strobe(1, 16'($urandom), 1'b0);
      idle(3);
    end
    check("b_lfo_count", offq_b.size(), 7);
    if (offq_b.size() == 7)
      for (int k = 0; k < 7; k++) check("b_lfo_offset", offq_b[k], lfo_exp[k]);

    // Overrun on b: drop at +2, accept at the out_valid cycle
    strobe(1, 16'h0101, 1'b0);
    ke = ecnt;
    idle(1);
    strobe(1, 16'h0202, 1'b0);
    idle(1);
    strobe(1, 16'h0303, 1'b0);
    check("b_ovr_set", int'(ovr_b), 1);
    check("b_ovr_outv_edge", (oute_b.size() > 0) ? oute_b[$] : -1, ke + 3);
    idle(5);
    check("b_ovr_sticky", int'(ovr_b), 1);
    check("b_ovr_wr_once", (waq_b.size() >= 2) ? waq_b[$ - 1] : -1, 7);
    check("b_ovr_accept", (waq_b.size() >= 1) ? waq_b[$] : -1, 8);

    // Randomised traffic with occasional resets and bypass
    for (int c = 0; c < 700; c++) begin
      rst_a = ($urandom_range(0, 99) == 0);
      sv_a  = ($urandom_range(0, 2) == 0);
      sin_a = 16'($urandom);
      byp_a = ($urandom_range(0, 7) == 0);
      rst_b = ($urandom_range(0, 99) == 0);
      sv_b  = ($urandom_range(0, 3) == 0);
      sin_b = 16'($urandom);
      byp_b = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst_a = 1'b0; rst_b = 1'b0; sv_a = 1'b0; sv_b = 1'b0;
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
